// File: rtl/dmem_if.sv
// Load/store request and response bundle between the core MEM stage and the data-memory responder.
interface dmem_if #(
  parameter int unsigned XLEN = 32
);
  logic            m_mem_read;
  logic            m_mem_write;
  logic [2:0]      m_mem_mode;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic            req_ready;
  logic            resp_valid;
  logic [XLEN-1:0] m_data;
  logic            misalign_err;

  modport master (
    output m_mem_read, m_mem_write, m_mem_mode, addr, wdata,
    input  req_ready, resp_valid, m_data, misalign_err
  );

  modport slave (
    input  m_mem_read, m_mem_write, m_mem_mode, addr, wdata,
    output req_ready, resp_valid, m_data, misalign_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data memory that answers one load/store at a time after WAIT_CYCLES wait states,
// returning extended load data with a one-cycle response strobe and an error qualifier.
module dmem_responder #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic  clk,
  input  logic  rst,
  dmem_if.slave bus
);
  localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              cap_rd;
  logic              cap_wr;
  logic [2:0]        cap_mode;
  logic [ADDR_W+1:0] cap_addr;
  logic [31:0]       cap_wdata;

  logic [31:0]       mem [DEPTH_WORDS];

  logic              sel_rd;
  logic              sel_wr;
  logic [2:0]        sel_mode;
  logic [ADDR_W+1:0] sel_addr;
  logic              err_c;
  logic [31:0]       rd_word;
  logic [7:0]        lane_byte;
  logic [15:0]       lane_half;
  logic [XLEN-1:0]   resp_data_c;
  logic [3:0]        be;
  logic [31:0]       st_word;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^bus.addr[XLEN-1:ADDR_W+2];

  // In IDLE the response is built from the live request (zero-wait path), otherwise from the captured one.
  always_comb begin
    sel_rd   = cap_rd;
    sel_wr   = cap_wr;
    sel_mode = cap_mode;
    sel_addr = cap_addr;
    if (state == S_IDLE) begin
      sel_rd   = bus.m_mem_read;
      sel_wr   = bus.m_mem_write;
      sel_mode = bus.m_mem_mode;
      sel_addr = bus.addr[ADDR_W+1:0];
    end
  end

  always_comb begin
    err_c = sel_rd && sel_wr;
    case (sel_mode)
      3'b001, 3'b101:         if (sel_addr[0]) err_c = 1'b1;
      3'b010:                 if (sel_addr[1:0] != 2'b00) err_c = 1'b1;
      3'b011, 3'b110, 3'b111: err_c = 1'b1;
      default: ;
    endcase
    if (sel_wr && sel_mode[2]) err_c = 1'b1;
  end

  // Load path: lane extraction and sign/zero extension.
  always_comb begin
    rd_word     = mem[sel_addr[ADDR_W+1:2]];
    lane_byte   = rd_word[{sel_addr[1:0], 3'b000} +: 8];
    lane_half   = sel_addr[1] ? rd_word[31:16] : rd_word[15:0];
    resp_data_c = '0;
    if (sel_rd && !err_c) begin
      case (sel_mode)
        3'b000:  resp_data_c = {{(XLEN-8){lane_byte[7]}}, lane_byte};
        3'b001:  resp_data_c = {{(XLEN-16){lane_half[15]}}, lane_half};
        3'b010:  resp_data_c = XLEN'(rd_word);
        3'b100:  resp_data_c = XLEN'(lane_byte);
        3'b101:  resp_data_c = XLEN'(lane_half);
        default: resp_data_c = '0;
      endcase
    end
  end

  // Store path: replicate the store data across lanes and pick the byte enables.
  always_comb begin
    case (cap_mode[1:0])
      2'b00: begin
        be      = 4'b0001 << cap_addr[1:0];
        st_word = {4{cap_wdata[7:0]}};
      end
      2'b01: begin
        be      = cap_addr[1] ? 4'b1100 : 4'b0011;
        st_word = {2{cap_wdata[15:0]}};
      end
      default: begin
        be      = 4'b1111;
        st_word = cap_wdata;
      end
    endcase
  end

  // Array is not reset; a reset during RESP leaves the FSM in IDLE so the store never lands.
  always_ff @(posedge clk) begin
    if (state == S_RESP && cap_wr && !err_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[cap_addr[ADDR_W+1:2]][8*i +: 8] <= st_word[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      cnt              <= '0;
      cap_rd           <= 1'b0;
      cap_wr           <= 1'b0;
      cap_mode         <= '0;
      cap_addr         <= '0;
      cap_wdata        <= '0;
      bus.req_ready    <= 1'b1;
      bus.resp_valid   <= 1'b0;
      bus.m_data       <= '0;
      bus.misalign_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.m_mem_read || bus.m_mem_write) begin
            cap_rd        <= bus.m_mem_read;
            cap_wr        <= bus.m_mem_write;
            cap_mode      <= bus.m_mem_mode;
            cap_addr      <= bus.addr[ADDR_W+1:0];
            cap_wdata     <= bus.wdata[31:0];
            bus.req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state            <= S_RESP;
              bus.resp_valid   <= 1'b1;
              bus.m_data       <= resp_data_c;
              bus.misalign_err <= err_c;
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_W'(WAIT_CYCLES - 1);
            end
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state            <= S_RESP;
            bus.resp_valid   <= 1'b1;
            bus.m_data       <= resp_data_c;
            bus.misalign_err <= err_c;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESP: begin
          state            <= S_IDLE;
          bus.req_ready    <= 1'b1;
          bus.resp_valid   <= 1'b0;
          bus.m_data       <= '0;
          bus.misalign_err <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances with WAIT_CYCLES 0, 1 and 15 checked
// against a byte-level reference memory model.
module tb_dmem_responder;
  localparam int unsigned XLEN = 32;
  localparam logic [2:0] MB = 3'b000, MH = 3'b001, MW = 3'b010, MBU = 3'b100, MHU = 3'b101;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [2:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_if #(.XLEN(XLEN)) bus0 ();
  dmem_if #(.XLEN(XLEN)) bus1 ();
  dmem_if #(.XLEN(XLEN)) bus2 ();

  dmem_responder #(.XLEN(XLEN), .DEPTH_WORDS(1024), .WAIT_CYCLES(0))  dut0 (.clk(clk), .rst(rst), .bus(bus0));
  dmem_responder #(.XLEN(XLEN), .DEPTH_WORDS(1024), .WAIT_CYCLES(1))  dut1 (.clk(clk), .rst(rst), .bus(bus1));
  dmem_responder #(.XLEN(XLEN), .DEPTH_WORDS(1024), .WAIT_CYCLES(15)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  exp_t        exp_q [$];
  logic [31:0] ref_mem [3][1024];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          resp_cnt2 = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus2.resp_valid === 1'b1) resp_cnt2 <= resp_cnt2 + 1;
  end

  function automatic txn_t ld(logic [2:0] m, logic [31:0] a);
    return '{rd: 1'b1, wr: 1'b0, mode: m, addr: a, wdata: 32'h0};
  endfunction

  function automatic txn_t st(logic [2:0] m, logic [31:0] a, logic [31:0] d);
    return '{rd: 1'b0, wr: 1'b1, mode: m, addr: a, wdata: d};
  endfunction

  function automatic int lat_of(int s);
    return (s == 0) ? 1 : (s == 1) ? 2 : 16;
  endfunction

  function automatic logic get_ready(int s);
    case (s)
      0:       return bus0.req_ready;
      1:       return bus1.req_ready;
      default: return bus2.req_ready;
    endcase
  endfunction

  function automatic logic get_valid(int s);
    case (s)
      0:       return bus0.resp_valid;
      1:       return bus1.resp_valid;
      default: return bus2.resp_valid;
    endcase
  endfunction

  function automatic logic [31:0] get_data(int s);
    case (s)
      0:       return bus0.m_data;
      1:       return bus1.m_data;
      default: return bus2.m_data;
    endcase
  endfunction

  function automatic logic get_err(int s);
    case (s)
      0:       return bus0.misalign_err;
      1:       return bus1.misalign_err;
      default: return bus2.misalign_err;
    endcase
  endfunction

  task automatic drive(int s, txn_t t);
    case (s)
      0: begin
        bus0.m_mem_read = t.rd; bus0.m_mem_write = t.wr; bus0.m_mem_mode = t.mode;
        bus0.addr = t.addr; bus0.wdata = t.wdata;
      end
      1: begin
        bus1.m_mem_read = t.rd; bus1.m_mem_write = t.wr; bus1.m_mem_mode = t.mode;
        bus1.addr = t.addr; bus1.wdata = t.wdata;
      end
      default: begin
        bus2.m_mem_read = t.rd; bus2.m_mem_write = t.wr; bus2.m_mem_mode = t.mode;
        bus2.addr = t.addr; bus2.wdata = t.wdata;
      end
    endcase
  endtask

  // Reference model: decides the error, extracts/extends load data, and applies stores bytewise.
  function automatic exp_t model(int s, txn_t t);
    exp_t        e;
    logic [31:0] w;
    logic [15:0] h;
    logic [7:0]  b;
    int          idx;
    int          off;
    idx = int'(t.addr[11:2]);
    off = int'(t.addr[1:0]);
    e.err = (t.rd && t.wr) || (t.wr && t.mode[2]) || t.mode == 3'b011 || t.mode == 3'b110 ||
            t.mode == 3'b111 || (t.mode[1:0] == 2'b01 && t.addr[0]) ||
            (t.mode == 3'b010 && t.addr[1:0] != 2'b00);
    e.data = 32'h0;
    if (!e.err) begin
      w = ref_mem[s][idx];
      b = w[8*off +: 8];
      h = (off >= 2) ? w[31:16] : w[15:0];
      if (t.rd) begin
        case (t.mode)
          MB:      e.data = {{24{b[7]}}, b};
          MH:      e.data = {{16{h[15]}}, h};
          MW:      e.data = w;
          MBU:     e.data = {24'h0, b};
          default: e.data = {16'h0, h};
        endcase
      end else begin
        if (t.mode[1:0] == 2'b00)      w[8*off +: 8]  = t.wdata[7:0];
        else if (t.mode[1:0] == 2'b01) w[8*off +: 16] = t.wdata[15:0];
        else                           w              = t.wdata;
        ref_mem[s][idx] = w;
      end
    end
    return e;
  endfunction

  task automatic issue(int s, txn_t t, bit push);
    int g;
    g = 0;
    @(negedge clk);
    while (get_ready(s) !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) begin
      total++; bad++;
      $display("FAIL issue_ready sel=%0d: req_ready never high", s);
    end
    if (push) exp_q.push_back(model(s, t));
    drive(s, t);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    drive(s, '0);
  endtask

  task automatic collect(int s, output bit got, output logic [31:0] d, output logic e,
                         output int lat, output int busy, output logic pv, output logic [31:0] pd,
                         output logic pr);
    int g;
    g = 0; got = 1'b0; busy = 0;
    @(negedge clk);
    while (g < 40) begin
      if (get_ready(s) === 1'b0) busy++;
      if (get_valid(s) === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      g++;
    end
    lat = cyc - acc_cyc + 1;
    d = get_data(s);
    e = get_err(s);
    @(negedge clk);
    pv = get_valid(s);
    pd = get_data(s);
    pr = get_ready(s);
  endtask

  task automatic test_reset();
    drive(0, '0); drive(1, '0); drive(2, '0);
    repeat (3) @(negedge clk);
    total++; if (bus1.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus1.req_ready); end
    total++; if (bus1.resp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus1.resp_valid); end
    total++; if (bus1.m_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", bus1.m_data); end
    total++; if (bus1.misalign_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus1.misalign_err); end
    total++; if (bus0.req_ready !== 1'b1 || bus2.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_others got=%b%b want=11", bus0.req_ready, bus2.req_ready); end
    rst = 1'b0;
  endtask

  task automatic test_store_load();
    txn_t tx [12];
    exp_t e;
    bit got; logic [31:0] d, pd; logic er, pv, pr; int lat, busy;
    tx[0]  = st(MW, 32'h10, 32'hDEADBEEF);  tx[1]  = ld(MW, 32'h10);
    tx[2]  = st(MW, 32'h10, 32'h11223344);  tx[3]  = st(MB, 32'h13, 32'h000000A5);
    tx[4]  = ld(MW, 32'h10);                tx[5]  = ld(MB, 32'h13);
    tx[6]  = ld(MBU, 32'h13);               tx[7]  = st(MW, 32'h20, 32'h0);
    tx[8]  = st(MH, 32'h22, 32'h00008001);  tx[9]  = ld(MH, 32'h22);
    tx[10] = ld(MHU, 32'h22);               tx[11] = ld(MW, 32'h20);
    for (int i = 0; i < 12; i++) begin
      issue(1, tx[i], 1'b1);
      collect(1, got, d, er, lat, busy, pv, pd, pr);
      e = exp_q.pop_front();
      total++; if (!got) begin bad++; $display("FAIL sl[%0d]_resp no resp_valid within bound", i); end
      total++; if (d !== e.data) begin bad++; $display("FAIL sl[%0d]_data got=%h want=%h", i, d, e.data); end
      total++; if (er !== e.err) begin bad++; $display("FAIL sl[%0d]_err got=%b want=%b", i, er, e.err); end
      total++; if (lat !== 2) begin bad++; $display("FAIL sl[%0d]_latency got=%0d want=2", i, lat); end
      total++; if (busy !== 2) begin bad++; $display("FAIL sl[%0d]_busy got=%0d want=2", i, busy); end
      total++; if (pv !== 1'b0 || pd !== 32'h0 || pr !== 1'b1) begin
        bad++; $display("FAIL sl[%0d]_after got=v%b d%h r%b want=v0 d0 r1", i, pv, pd, pr);
      end
    end
  endtask

  task automatic test_errors();
    txn_t tx [10];
    exp_t e;
    bit got; logic [31:0] d, pd; logic er, pv, pr; int lat, busy;
    tx[0] = st(MW, 32'h04, 32'h55667788);   tx[1] = ld(MW, 32'h06);
    tx[2] = st(MH, 32'h05, 32'h0000FFFF);   tx[3] = ld(MW, 32'h04);
    tx[4] = '{rd: 1'b1, wr: 1'b1, mode: MW, addr: 32'h08, wdata: 32'h1};
    tx[5] = ld(3'b011, 32'h0);              tx[6] = ld(3'b110, 32'h0);
    tx[7] = st(MBU, 32'h04, 32'h000000EE);  tx[8] = ld(MW, 32'h04);
    tx[9] = ld(MHU, 32'h03);
    for (int i = 0; i < 10; i++) begin
      issue(1, tx[i], 1'b1);
      collect(1, got, d, er, lat, busy, pv, pd, pr);
      e = exp_q.pop_front();
      total++; if (!got) begin bad++; $display("FAIL err[%0d]_resp no resp_valid within bound", i); end
      total++; if (d !== e.data) begin bad++; $display("FAIL err[%0d]_data got=%h want=%h", i, d, e.data); end
      total++; if (er !== e.err) begin bad++; $display("FAIL err[%0d]_flag got=%b want=%b", i, er, e.err); end
      total++; if (pv !== 1'b0 || pr !== 1'b1) begin bad++; $display("FAIL err[%0d]_after got=v%b r%b want=v0 r1", i, pv, pr); end
    end
  endtask

  task automatic test_wait_states();
    txn_t tx [3];
    exp_t e;
    bit got; logic [31:0] d, pd; logic er, pv, pr; int lat, busy, s;
    tx[0] = st(MW, 32'h40, 32'h0BADF00D); tx[1] = ld(MW, 32'h40); tx[2] = ld(MB, 32'h41);
    for (int k = 0; k < 2; k++) begin
      s = (k == 0) ? 0 : 2;
      for (int i = 0; i < 3; i++) begin
        issue(s, tx[i], 1'b1);
        collect(s, got, d, er, lat, busy, pv, pd, pr);
        e = exp_q.pop_front();
        total++; if (!got) begin bad++; $display("FAIL ws%0d[%0d]_resp no resp_valid within bound", s, i); end
        total++; if (d !== e.data) begin bad++; $display("FAIL ws%0d[%0d]_data got=%h want=%h", s, i, d, e.data); end
        total++; if (er !== e.err) begin bad++; $display("FAIL ws%0d[%0d]_err got=%b want=%b", s, i, er, e.err); end
        total++; if (lat !== lat_of(s)) begin bad++; $display("FAIL ws%0d[%0d]_latency got=%0d want=%0d", s, i, lat, lat_of(s)); end
      end
    end
  endtask

  task automatic test_ignored_strobes();
    exp_t e;
    bit got; logic [31:0] d, pd; logic er, pv, pr; int lat, busy, c0;
    c0 = resp_cnt2;
    issue(2, ld(MW, 32'h40), 1'b1);
    repeat (4) begin
      @(negedge clk);
      drive(2, '{rd: 1'b1, wr: 1'b1, mode: MW, addr: 32'h44, wdata: 32'h5});
    end
    @(negedge clk);
    drive(2, '0);
    collect(2, got, d, er, lat, busy, pv, pd, pr);
    e = exp_q.pop_front();
    total++; if (!got) begin bad++; $display("FAIL ign_resp no resp_valid within bound"); end
    total++; if (d !== e.data || er !== e.err) begin bad++; $display("FAIL ign_data got=%h/%b want=%h/%b", d, er, e.data, e.err); end
    total++; if (lat !== 16) begin bad++; $display("FAIL ign_latency got=%0d want=16", lat); end
    repeat (25) @(negedge clk);
    total++; if (resp_cnt2 - c0 !== 1) begin bad++; $display("FAIL ign_count got=%0d want=1", resp_cnt2 - c0); end
  endtask

  task automatic test_alias_reset();
    txn_t tx [4];
    exp_t e;
    bit got; logic [31:0] d, pd; logic er, pv, pr; int lat, busy, g;
    tx[0] = st(MW, 32'h0, 32'h01020304);    tx[1] = st(MW, 32'h1000, 32'hA1A2A3A4);
    tx[2] = ld(MW, 32'h0);                  tx[3] = st(MW, 32'h30, 32'hCAFEF00D);
    for (int i = 0; i < 4; i++) begin
      issue(1, tx[i], 1'b1);
      collect(1, got, d, er, lat, busy, pv, pd, pr);
      e = exp_q.pop_front();
      total++; if (!got || d !== e.data || er !== e.err) begin
        bad++; $display("FAIL alias[%0d] got=%b/%h/%b want=1/%h/%b", i, got, d, er, e.data, e.err);
      end
    end
    // Store abandoned by reset mid-RESP: nothing is pushed and the model keeps the old word.
    issue(1, st(MW, 32'h30, 32'h12345678), 1'b0);
    g = 0;
    @(negedge clk);
    while (bus1.resp_valid !== 1'b1 && g < 10) begin
      @(negedge clk);
      g++;
    end
    total++; if (g >= 10) begin bad++; $display("FAIL rst_resp_seen got=no want=yes"); end
    #2 rst = 1'b1;
    #1;
    total++; if (bus1.req_ready !== 1'b1 || bus1.resp_valid !== 1'b0 || bus1.m_data !== 32'h0 || bus1.misalign_err !== 1'b0) begin
      bad++; $display("FAIL rst_immediate got=r%b v%b d%h e%b want=r1 v0 d0 e0", bus1.req_ready, bus1.resp_valid, bus1.m_data, bus1.misalign_err);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus1.req_ready !== 1'b1 || bus1.resp_valid !== 1'b0) begin
      bad++; $display("FAIL rst_idle got=r%b v%b want=r1 v0", bus1.req_ready, bus1.resp_valid);
    end
    issue(1, ld(MW, 32'h30), 1'b1);
    collect(1, got, d, er, lat, busy, pv, pd, pr);
    e = exp_q.pop_front();
    total++; if (!got || d !== e.data || er !== e.err) begin
      bad++; $display("FAIL rst_store_dropped got=%b/%h/%b want=1/%h/%b", got, d, er, e.data, e.err);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_errors();
    test_wait_states();
    test_ignored_strobes();
    test_alias_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the far side of the core's MEM-stage load/store interface.
- Accepts one read or write per transaction: op strobes, funct3 mode, byte address, store data.
- Services it from an internal word-organised array after a programmable number of wait states.
- Returns sign/zero-extended load data, a one-cycle response strobe and an error flag.

Parameters:
- XLEN, 32, data and address width.
- DEPTH_WORDS, 1024, array depth in 32-bit words (power of 2); ADDR_W = log2(DEPTH_WORDS).
- WAIT_CYCLES, 1, wait states between accept and response, legal 0..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- m_mem_read  in  1  load request strobe.
- m_mem_write  in  1  store request strobe.
- m_mem_mode  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  XLEN  byte address (ex_result).
- wdata  in  XLEN  store data (rs2_data), low bytes used for B/H.
- req_ready  out  1  responder idle; request accepted on a rising edge when high.
- resp_valid  out  1  one-cycle response strobe.
- m_data  out  XLEN  load result, valid while resp_valid is high.
- misalign_err  out  1  error qualifier, valid while resp_valid is high.

Behaviour:
- Reset (async, immediate): state IDLE, req_ready=1, resp_valid=0, m_data=0, misalign_err=0, wait counter=0.
- Reset does not clear array contents.
- FSM states: IDLE, WAIT, RESP.
- IDLE
  - req_ready=1.
  - If m_mem_read or m_mem_write is high at a rising edge: capture op, mode, addr, wdata.
  - Next state is WAIT with counter=WAIT_CYCLES-1, or RESP if WAIT_CYCLES=0.
- WAIT
  - req_ready=0.
  - Counter decrements each cycle; at 0 the next state is RESP.
- RESP
  - req_ready=0 and resp_valid=1 for exactly one cycle; next state IDLE.
- Latency: resp_valid rises WAIT_CYCLES+1 cycles after the accepting edge. Back-to-back throughput is one transaction per WAIT_CYCLES+2 cycles.
- Strobes seen while req_ready=0 are ignored; the requester holds its request until accepted.
- Word index is addr[ADDR_W+1:2]. Higher address bits are ignored, so addresses alias modulo 4*DEPTH_WORDS.
- Error conditions (misalign_err=1 in RESP, m_data=0, array unchanged):
  - m_mem_read and m_mem_write both high at accept.
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
  - Mode 011, 110 or 111.
  - Store with mode[2]=1.
- Load, no error:
  - Lane byte = addr[1:0]; lane half = addr[1].
  - B and H sign-extend to XLEN; BU and HU zero-extend; W returns the full word.
  - Data is read from the array as of the RESP cycle.
- Store, no error:
  - Byte-enable merge into the target word at the rising edge ending RESP.
  - Unselected bytes are preserved.
  - m_data=0 and misalign_err=0 during RESP.
- Read-after-write: a load accepted after a store's RESP cycle returns the stored value.
- Reset asserted during WAIT or RESP abandons the transaction and the pending store is not performed. The next cycle after release is IDLE.
- Outside RESP: resp_valid=0, misalign_err=0, and m_data holds 0.

Test Plan:
- Reset, then SW addr=0x10 wdata=0xDEADBEEF with WAIT_CYCLES=1:
  - req_ready low 2 cycles; resp_valid 2 cycles after accept; misalign_err=0.
  - Then LW 0x10 -> m_data=0xDEADBEEF.
- SB addr=0x13 wdata=0x000000A5 into word 0x11223344:
  - LW 0x10 -> 0xA5223344.
  - LB 0x13 -> 0xFFFFFFA5; LBU 0x13 -> 0x000000A5.
- SH addr=0x22 wdata=0x8001 into a zeroed word:
  - LH 0x22 -> 0xFFFF8001; LHU 0x22 -> 0x00008001; LW 0x20 -> 0x80010000.
- Errors:
  - LW addr=0x06 -> resp_valid with misalign_err=1, m_data=0.
  - SH addr=0x05 -> misalign_err=1; a following LW 0x04 shows the word unchanged.
  - Both strobes high -> misalign_err=1.
- WAIT_CYCLES=0 vs 15: resp_valid arrives exactly 1 and 16 cycles after accept. Strobes pulsed while req_ready=0 produce no extra response.
- Aliasing and reset:
  - With DEPTH_WORDS=1024, SW addr=0x1000 aliases to 0x0.
  - Assert rst in the RESP cycle of SW 0x30 wdata=0x12345678: outputs reset immediately; a later LW 0x30 returns the prior contents.
